// File: rtl/ps2_key_receiver_if.sv
// ps2_key_receiver_if: decoded keyboard outputs of the PS/2 front end.
// The receiver drives these signals through the master modport.
// A consumer such as keyboard_input reads them through the slave modport.
interface ps2_key_receiver_if;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic [7:0] ps2_out;
    logic       ps2_extended;
    logic       frame_error;

    modport master (
        output ps2_key_data,
        output ps2_key_pressed,
        output ps2_out,
        output ps2_extended,
        output frame_error
    );

    modport slave (
        input ps2_key_data,
        input ps2_key_pressed,
        input ps2_out,
        input ps2_extended,
        input frame_error
    );
endinterface

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 keyboard front end.
// The design works in several stages:
//   - It synchronizes and filters the raw PS/2 pins.
//   - It deframes 11-bit device frames, checking odd parity and the stop bit, with a watchdog.
//   - It strips the E0 (extended) and F0 (break) prefixes.
//   - It announces each make code with a clean ps2_key_pressed pulse.
// Optional feature macro: PS2_REPEAT_FILTER_EN.
//   - When it is defined, typematic repeats of the currently held key are suppressed.
//   - They still update ps2_out, but they produce no pulse.
module ps2_key_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int PULSE_CYCLES   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ps2_clk,
    input  logic               ps2_dat,
    ps2_key_receiver_if.master key_if
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

    frame_state_t    state, state_next;
    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            clk_filt, fall;
    logic [FW-1:0]   filt_cnt;
    logic [7:0]      shift_reg;
    logic [2:0]      bit_cnt;
    logic            parity_ok;
    logic [TW-1:0]   wd_cnt;
    logic            timeout_hit, byte_done, err_now;
    logic            is_code, is_make, make_accept;
    logic            ext_flag, brk_flag;
    logic [7:0]      key_data_q, out_q;
    logic            extended_q, frame_error_q;
    logic            pulse_high, pulse_arm;
    logic [PW-1:0]   pulse_cnt;

    // Two-flop synchronizers; the pins idle high, so the flops reset high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter on the clock pin; a fall strobe is emitted when the filtered level drops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
                fall     <= ~clk_s2;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // Frame state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: the watchdog has priority; otherwise the FSM advances one bit per fall strobe.
    always_comb begin
        state_next  = state;
        byte_done   = 1'b0;
        err_now     = 1'b0;
        timeout_hit = (state != IDLE) && !fall && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
        if (timeout_hit) begin
            state_next = IDLE;
            err_now    = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) state_next = DATA;
                    else         err_now    = 1'b1;
                end
                DATA:   if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY: state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    if (dat_s2 && parity_ok) byte_done = 1'b1;
                    else                     err_now   = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Frame datapath: LSB-first shifter, bit counter, parity result and inter-edge watchdog.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            parity_ok <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            if (state == IDLE || fall) wd_cnt <= '0;
            else                       wd_cnt <= wd_cnt + TW'(1);
            if (fall) begin
                case (state)
                    IDLE: bit_cnt <= '0;
                    DATA: begin
                        shift_reg <= {dat_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                    PARITY:  parity_ok <= ^{shift_reg, dat_s2};
                    default: ;
                endcase
            end
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic       held_valid, held_ext, is_release;
    logic [7:0] held_code;

    // A make code matching the held key (code and extended bit) is a typematic repeat.
    always_comb begin
        is_code     = byte_done && (shift_reg != CODE_EXT) && (shift_reg != CODE_BRK);
        is_make     = is_code && !brk_flag;
        is_release  = is_code && brk_flag;
        make_accept = is_make && !(held_valid && held_code == shift_reg && held_ext == ext_flag);
    end

    // Held-key tracker: set by an accepted make, cleared by the matching release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            held_valid <= 1'b0;
            held_code  <= '0;
            held_ext   <= 1'b0;
        end else if (make_accept) begin
            held_valid <= 1'b1;
            held_code  <= shift_reg;
            held_ext   <= ext_flag;
        end else if (is_release && held_code == shift_reg && held_ext == ext_flag) begin
            held_valid <= 1'b0;
        end
    end
`else
    // Every make code is announced, including typematic repeats.
    always_comb begin
        is_code     = byte_done && (shift_reg != CODE_EXT) && (shift_reg != CODE_BRK);
        is_make     = is_code && !brk_flag;
        make_accept = is_make;
    end
`endif

    // Code layer: prefix flags, the raw byte, and the latched make code with its extended bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q         <= '0;
            key_data_q    <= '0;
            extended_q    <= 1'b0;
            ext_flag      <= 1'b0;
            brk_flag      <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= err_now;
            if (err_now) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_done) begin
                out_q <= shift_reg;
                if (shift_reg == CODE_EXT) begin
                    ext_flag <= 1'b1;
                end else if (shift_reg == CODE_BRK) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    if (make_accept) begin
                        key_data_q <= shift_reg;
                        extended_q <= ext_flag;
                    end
                end
            end
        end
    end

    // Pulse generator: low in the cycle the data changes, then high for PULSE_CYCLES; a new make restarts it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pulse_high <= 1'b0;
            pulse_arm  <= 1'b0;
            pulse_cnt  <= '0;
        end else if (make_accept) begin
            pulse_high <= 1'b0;
            pulse_arm  <= 1'b1;
            pulse_cnt  <= '0;
        end else if (pulse_arm) begin
            pulse_high <= 1'b1;
            pulse_arm  <= 1'b0;
            pulse_cnt  <= PW'(PULSE_CYCLES - 1);
        end else if (pulse_high) begin
            if (pulse_cnt == '0) pulse_high <= 1'b0;
            else                 pulse_cnt  <= pulse_cnt - PW'(1);
        end
    end

    assign key_if.ps2_key_data    = key_data_q;
    assign key_if.ps2_key_pressed = pulse_high;
    assign key_if.ps2_out         = out_q;
    assign key_if.ps2_extended    = extended_q;
    assign key_if.frame_error     = frame_error_q;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: directed PS/2 frames against a byte-level reference model.
// The monitor checks pulse shape and data stability on every cycle.
// After each frame, check_output compares the outputs, pulses and errors with the model.
module tb_ps2_key_receiver;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int PULSE_CYCLES   = 4;
    localparam int HALF_BIT       = 20;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_key_receiver_if key_if();

    ps2_key_receiver #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .PULSE_CYCLES(PULSE_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .key_if(key_if)
    );

    always #5 clock = ~clock;

    int num_checks = 0;
    int num_errors = 0;

    // Reference model state.
    logic [7:0] m_out, m_key, m_held_code;
    logic       m_ext, m_ext_flag, m_brk_flag, m_held_valid, m_held_ext;
    logic [8:0] exp_pulses[$];
    logic [8:0] got_pulses[$];
    int         exp_errors = 0;
    int         got_errors = 0;
    int         total_pulses = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_out = 8'h00; m_key = 8'h00; m_ext = 1'b0;
        m_ext_flag = 1'b0; m_brk_flag = 1'b0;
        m_held_valid = 1'b0; m_held_code = 8'h00; m_held_ext = 1'b0;
    endtask

    task automatic model_error();
        exp_errors++;
        m_ext_flag = 1'b0;
        m_brk_flag = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic is_repeat;
        m_out = b;
        if (b == 8'hE0) begin
            m_ext_flag = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk_flag = 1'b1;
        end else if (m_brk_flag) begin
            if (m_held_valid && m_held_code == b && m_held_ext == m_ext_flag) m_held_valid = 1'b0;
            m_ext_flag = 1'b0;
            m_brk_flag = 1'b0;
        end else begin
`ifdef PS2_REPEAT_FILTER_EN
            is_repeat = m_held_valid && m_held_code == b && m_held_ext == m_ext_flag;
`else
            is_repeat = 1'b0;
`endif
            if (!is_repeat) begin
                m_key = b;
                m_ext = m_ext_flag;
                exp_pulses.push_back({m_ext_flag, b});
                m_held_valid = 1'b1;
                m_held_code  = b;
                m_held_ext   = m_ext_flag;
            end
            m_ext_flag = 1'b0;
            m_brk_flag = 1'b0;
        end
    endtask

    // Per-cycle monitor: data must be stable one cycle before and throughout each pulse.
    logic       prev_pressed = 1'b0;
    logic       prev_fe = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         high_len = 0;
    always @(negedge clock) begin
        if (!reset) begin
            prev_pressed = 1'b0;
            prev_fe      = 1'b0;
            high_len     = 0;
            prev_data    = key_if.ps2_key_data;
        end else begin
            if (key_if.ps2_key_pressed) begin
                if (!prev_pressed) begin
                    check("data_setup", key_if.ps2_key_data, prev_data);
                    got_pulses.push_back({key_if.ps2_extended, key_if.ps2_key_data});
                    total_pulses++;
                    high_len = 1;
                end else begin
                    check("data_hold", key_if.ps2_key_data, prev_data);
                    high_len++;
                end
            end else if (prev_pressed) begin
                check("pulse_width", high_len, PULSE_CYCLES);
            end
            if (key_if.frame_error) begin
                check("frame_error_single", prev_fe, 1'b0);
                if (!prev_fe) got_errors++;
            end
            prev_pressed = key_if.ps2_key_pressed;
            prev_fe      = key_if.frame_error;
            prev_data    = key_if.ps2_key_data;
        end
    end

    task automatic check_output(input string name);
        int n;
        check({name, " ps2_out"}, key_if.ps2_out, m_out);
        check({name, " ps2_key_data"}, key_if.ps2_key_data, m_key);
        check({name, " ps2_extended"}, key_if.ps2_extended, m_ext);
        check({name, " pulse_count"}, got_pulses.size(), exp_pulses.size());
        n = (got_pulses.size() < exp_pulses.size()) ? got_pulses.size() : exp_pulses.size();
        for (int i = 0; i < n; i++) check({name, " pulse_payload"}, got_pulses[i], exp_pulses[i]);
        check({name, " frame_error_count"}, got_errors, exp_errors);
        got_pulses.delete();
        exp_pulses.delete();
        got_errors = 0;
        exp_errors = 0;
    endtask

    task automatic send_bit(input logic v);
        @(negedge clock);
        ps2_dat = v;
        repeat (HALF_BIT / 2) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (HALF_BIT) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (HALF_BIT / 2) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_parity);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ flip_parity);
        send_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (40) @(negedge clock);
        if (flip_parity) model_error();
        else             model_byte(b);
    endtask

    // Safety net so the run always terminates.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not reach the end, limit 60000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        #1 reset = 1'b0;
        repeat (5) @(negedge clock);
        check("reset ps2_out", key_if.ps2_out, 8'h00);
        check("reset ps2_key_data", key_if.ps2_key_data, 8'h00);
        check("reset ps2_key_pressed", key_if.ps2_key_pressed, 1'b0);
        check("reset ps2_extended", key_if.ps2_extended, 1'b0);
        check("reset frame_error", key_if.frame_error, 1'b0);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check_output("idle_after_reset");

        // Plain make code.
        send_frame(8'h1C, 1'b0);
        check_output("make_1C");
        check("lit 1C key", key_if.ps2_key_data, 8'h1C);
        check("lit 1C pulses", total_pulses, 1);

        // Extended make code.
        send_frame(8'hE0, 1'b0);
        check_output("prefix_E0");
        check("lit E0 no pulse", total_pulses, 1);
        send_frame(8'h74, 1'b0);
        check_output("ext_74");
        check("lit 74 extended", key_if.ps2_extended, 1'b1);
        check("lit 74 pulses", total_pulses, 2);

        // Release sequence.
        send_frame(8'hF0, 1'b0);
        check_output("prefix_F0");
        check("lit F0 out", key_if.ps2_out, 8'hF0);
        send_frame(8'h1C, 1'b0);
        check_output("release_1C");
        check("lit release key kept", key_if.ps2_key_data, 8'h74);
        check("lit release no pulse", total_pulses, 2);

        // A high start bit while idle is a framing error.
        send_bit(1'b1);
        repeat (40) @(negedge clock);
        model_error();
        check_output("bad_start");

        // Parity error.
        send_frame(8'h16, 1'b1);
        check_output("bad_parity_16");
        check("lit parity key kept", key_if.ps2_key_data, 8'h74);

        // Prefix followed by a stalled frame; the timeout must drop the extended flag.
        send_frame(8'hE0, 1'b0);
        check_output("prefix_E0_before_timeout");
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        repeat (TIMEOUT_CYCLES + 100) @(negedge clock);
        model_error();
        check_output("timeout");
        send_frame(8'h3E, 1'b0);
        check_output("after_timeout_3E");
        check("lit 3E not extended", key_if.ps2_extended, 1'b0);
        check("lit 3E pulses", total_pulses, 3);

        // Reset in the middle of a frame.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        reset = 1'b0;
        ps2_dat = 1'b1;
        repeat (10) @(negedge clock);
        check("lit midreset key", key_if.ps2_key_data, 8'h00);
        check("lit midreset out", key_if.ps2_out, 8'h00);
        check("lit midreset pressed", key_if.ps2_key_pressed, 1'b0);
        reset = 1'b1;
        model_reset();
        repeat (20) @(negedge clock);
        check_output("after_midreset");
        send_frame(8'h2D, 1'b0);
        check_output("make_2D");
        check("lit 2D key", key_if.ps2_key_data, 8'h2D);
        check("lit 2D pulses", total_pulses, 4);

        // Typematic repeats, then release and press again.
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_output("repeat_1C");
`ifdef PS2_REPEAT_FILTER_EN
        check("lit repeat pulses", total_pulses, 5);
`else
        check("lit repeat pulses", total_pulses, 7);
`endif
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_output("release_repress_1C");
`ifdef PS2_REPEAT_FILTER_EN
        check("lit repress pulses", total_pulses, 6);
`else
        check("lit repress pulses", total_pulses, 8);
`endif
        check("lit final key", key_if.ps2_key_data, 8'h1C);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end
endmodule

// File: doc/ps2_key_receiver.md
# ps2_key_receiver

Front end of the keyboard path. It deserializes raw PS/2 device frames from the keyboard pins and strips the `E0` (extended) and `F0` (break) prefixes. It then presents each make code on `ps2_key_data` with a clean `ps2_key_pressed` pulse. `keyboard_input` consumes these outputs: it samples `ps2_key_data` on the rising edge of `ps2_key_pressed` and checks `ps2_out` against `F0`.

## Interface
- `FILTER_LEN`, 8: system clocks the synchronized `ps2_clk` must hold a new level before it is accepted.
- `TIMEOUT_CYCLES`, 250000: max system clocks between falling edges inside a frame (5 ms at 50 MHz).
- `PULSE_CYCLES`, 4: high time of `ps2_key_pressed`, in clocks; must be ≥1.
- `clock` input 1: system clock (50 MHz); all state on its rising edge.
- `reset` input 1: asynchronous, active-low; all registers go to reset values while low.
- `ps2_clk` input 1: raw PS/2 clock pin; asynchronous.
- `ps2_dat` input 1: raw PS/2 data pin; asynchronous.
- `ps2_key_data` output 8: last accepted make code, without prefixes. Reset `8'h00`.
- `ps2_key_pressed` output 1: pulse announcing a new `ps2_key_data`. Reset 0.
- `ps2_out` output 8: last valid raw byte, including `E0`/`F0`. Reset `8'h00`.
- `ps2_extended` output 1: 1 if the current `ps2_key_data` was prefixed by `E0`. Reset 0.
- `frame_error` output 1: one-cycle pulse on a framing/parity error or timeout. Reset 0.

## Operation
- **Input conditioning**
  - Both pins pass through 2-flop synchronizers.
  - The synchronized clock feeds a filter: the filtered level changes only after `FILTER_LEN` consecutive equal samples.
  - A falling edge of the filtered clock produces a one-cycle `fall` strobe.
  - Data is sampled from the synchronized `ps2_dat` in the `fall` cycle.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP)
  - IDLE: on `fall` with data 0 (start bit), go to DATA and clear the bit counter. On `fall` with data 1, stay in IDLE and pulse `frame_error`.
  - DATA: shift 8 bits, LSB first. Go to PARITY after bit 7.
  - PARITY: the sampled bit must make the 9-bit total odd (odd parity). Go to STOP.
  - STOP: if the bit is 1 and parity was OK, the byte is valid. Otherwise pulse `frame_error`. Always return to IDLE.
  - Timeout: in any non-IDLE state, a watchdog counts clocks since the last `fall`. Reaching `TIMEOUT_CYCLES` returns the FSM to IDLE, pulses `frame_error`, and clears the prefix flags.
- **Code layer** (on each valid byte `b`; `ps2_out <= b` always)
  - `b == E0`: set `ext_flag`.
  - `b == F0`: set `brk_flag`.
  - Otherwise, with `brk_flag` set: this is a release. Clear both flags; no pulse; `ps2_key_data` unchanged.
  - Otherwise (make code): `ps2_key_data <= b`, `ps2_extended <= ext_flag`, clear both flags, and start a pulse.
  - A `frame_error` also clears both flags.
- **Pulse generator**
  - `ps2_key_pressed` goes high the cycle after `ps2_key_data` updates, so data is stable a full cycle before the rising edge.
  - It stays high for `PULSE_CYCLES`.
  - If a new make arrives while the pulse is high: drive 0 for exactly one cycle, update the data in that cycle, then run a fresh full pulse.

## Timing
- From the `ps2_clk` pin fall to the `fall` strobe: 2 + `FILTER_LEN` clocks.
- From the STOP-bit `fall` strobe to the `ps2_out`/`ps2_key_data` update: 1 clock. `ps2_key_pressed` rises 1 clock after that.
- `frame_error` is high for exactly one clock.
- Reset asserted mid-frame: the FSM returns to IDLE, flags clear, outputs go to reset values, and no pulse occurs. After release, the first `fall` is accepted only as a start bit.
- A filtered clock that is low at reset release does not create a `fall`; the filter initializes to 1.

## Configuration
- `PS2_REPEAT_FILTER_EN`
  - Defined: the block tracks the held key (code + extended bit, set on make, cleared on its matching release or on reset). A make code equal to the held key is a typematic repeat: `ps2_out` still updates, but there is no pulse and `ps2_key_data` is unchanged. A different make code replaces the held key and pulses normally.
  - Undefined: every make code pulses, including typematic repeats.

## Test plan
- Frame `1C` (start 0, bits `00111000` LSB first, parity 0, stop 1) → `ps2_out=1C`, `ps2_key_data=1C`, one 4-cycle `ps2_key_pressed`, `ps2_extended=0`.
- Frames `E0 74` → no pulse after `E0`. After `74`: `ps2_key_data=74`, `ps2_extended=1`, one pulse, `ps2_out=74`.
- Frames `F0 1C` → `ps2_out=F0`, then `1C`; `ps2_key_data` retains its prior value; no pulse.
- Frame `16` with flipped parity → `frame_error` one cycle, no pulse. A following `E0` then a 6 ms gap mid-frame → timeout `frame_error`, and the next `3E` pulses with `ps2_extended=0`.
- `1C 1C 1C` → with `PS2_REPEAT_FILTER_EN`: one pulse; after `F0 1C 1C`: a second pulse. Without the macro: three pulses.
- `reset` low after 5 data bits, then a full `2D` frame → no output during the aborted frame; `2D` decoded with one pulse.
